// File: rtl/seq_mul_8.sv
// Iterative radix-2 shift-and-add multiplier: one add/shift per cycle over WIDTH
// iterations, then an optional two's-complement sign fix and a one-cycle done pulse.
module seq_mul_8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign sum       = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The adder carry-out shifts into the top of acc, so no partial-product bit is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        mq    <= b_mag;
                        acc   <= '0;
                        cnt   <= '0;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                RUN: begin
                    acc <= sum[WIDTH:1];
                    mq  <= {sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    product <= neg ? -{acc, mq} : {acc, mq};
                end
                default: ;
            endcase
        end
    end

endmodule
